offset_pair_loader: RTL and testbench

Parametrised successor to the per-core offset store. It streams a runtime-sized CSR offset array from HBM into per-core URAM through a credit-limited request/response handshake, and serves {offset[a], offset[a+1]} pairs to each core's front end with a fixed read latency. Each offset is stored once, in even/odd banks, rather than as a duplicated left/right entry, which halves URAM use. The block sits between the HBM pseudo-channel controllers and the per-core edge fetch stage.

---
 rtl/offset_pkg.sv | 17 +
 rtl/offset_bank_pair.sv | 92 +++++++++
 rtl/offset_pair_loader.sv | 114 +++++++++++
 tb/tb_offset_pair_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/offset_pkg.sv
// offset_pkg: shared state encoding, lane mapping and read-latency bounds for the offset pair loader
package offset_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    localparam int RD_LAT_MIN = 3;

    function automatic int core_ch(input int core, input int cores_per_ch);
        return core / cores_per_ch;
    endfunction

    // Bit offset of a core's lane inside the flattened multi-channel response bus
    function automatic int lane_base(input int core, input int cores_per_ch, input int dw);
        return (core_ch(core, cores_per_ch) * cores_per_ch + core % cores_per_ch) * dw;
    endfunction

endpackage

// File: rtl/offset_bank_pair.sv
// offset_bank_pair: one core's even/odd offset banks with a fixed-latency pair read
module offset_bank_pair
    import offset_pkg::*;
#(
    parameter int OFF_DWIDTH = 32,
    parameter int OFF_AWIDTH = 12,
    parameter int RD_LAT     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [OFF_AWIDTH-1:0] wr_idx,
    input  logic [OFF_DWIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    input  logic [OFF_AWIDTH-1:0] rd_addr,
    input  logic [OFF_AWIDTH:0]   rd_limit,
    output logic [OFF_DWIDTH-1:0] loffset,
    output logic [OFF_DWIDTH-1:0] roffset,
    output logic                  rd_dvalid,
    output logic                  rd_err
);

    localparam int BW    = OFF_AWIDTH - 1;
    localparam int DEPTH = 1 << BW;
    localparam int XD    = RD_LAT - 2;

    if (RD_LAT < RD_LAT_MIN) begin : g_bad_lat
        $error("offset_bank_pair: RD_LAT below minimum");
    end

    logic [OFF_DWIDTH-1:0] even_mem [DEPTH];
    logic [OFF_DWIDTH-1:0] odd_mem  [DEPTH];
    logic [OFF_AWIDTH:0]   a_inc;
    logic [BW-1:0]         ev_addr_q, od_addr_q;
    logic                  s1_v_q, s1_swap_q, s1_err_q;
    logic                  s2_v_q, s2_swap_q, s2_err_q;
    logic [OFF_DWIDTH-1:0] ev_q, od_q;
    logic [XD-1:0]         dv_q, de_q;
    logic [XD-1:0][OFF_DWIDTH-1:0] dl_q, dr_q;

    assign a_inc = {1'b0, rd_addr} + (OFF_AWIDTH + 1)'(1);

    always_ff @(posedge clk) begin
        if (wr_en && !wr_idx[0]) even_mem[wr_idx[OFF_AWIDTH-1:1]] <= wr_data;
        if (wr_en && wr_idx[0]) odd_mem[wr_idx[OFF_AWIDTH-1:1]] <= wr_data;
        ev_q <= even_mem[ev_addr_q];
        od_q <= odd_mem[od_addr_q];
    end

    // (a+1)>>1 equals a>>1 for even a, so one even-bank address covers both cases
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_addr_q <= '0;
            od_addr_q <= '0;
            s1_v_q    <= 1'b0;
            s1_swap_q <= 1'b0;
            s1_err_q  <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_swap_q <= 1'b0;
            s2_err_q  <= 1'b0;
            dv_q      <= '0;
            de_q      <= '0;
            dl_q      <= '0;
            dr_q      <= '0;
        end else begin
            ev_addr_q <= a_inc[OFF_AWIDTH-1:1];
            od_addr_q <= rd_addr[OFF_AWIDTH-1:1];
            s1_v_q    <= rd_valid;
            s1_swap_q <= rd_addr[0];
            s1_err_q  <= a_inc >= rd_limit;
            s2_v_q    <= s1_v_q;
            s2_swap_q <= s1_swap_q;
            s2_err_q  <= s1_err_q;
            dv_q[0]   <= s2_v_q;
            de_q[0]   <= s2_err_q;
            dl_q[0]   <= s2_swap_q ? od_q : ev_q;
            dr_q[0]   <= s2_swap_q ? ev_q : od_q;
            for (int i = 1; i < XD; i++) begin
                dv_q[i] <= dv_q[i-1];
                de_q[i] <= de_q[i-1];
                dl_q[i] <= dl_q[i-1];
                dr_q[i] <= dr_q[i-1];
            end
        end
    end

    assign loffset   = dl_q[XD-1];
    assign roffset   = dr_q[XD-1];
    assign rd_dvalid = dv_q[XD-1];
    assign rd_err    = de_q[XD-1];

endmodule

// File: rtl/offset_pair_loader.sv
// offset_pair_loader: credit-limited HBM loader of per-core CSR offsets with paired fixed-latency reads
module offset_pair_loader
    import offset_pkg::*;
#(
    parameter int CH_NUM          = 2,
    parameter int CORES_PER_CH    = 16,
    parameter int CORE_NUM        = CH_NUM * CORES_PER_CH,
    parameter int OFF_DWIDTH      = 32,
    parameter int OFF_AWIDTH      = 12,
    parameter int HBM_AWIDTH      = 33,
    parameter int MAX_OUTSTANDING = 32,
    parameter int RD_LAT          = 5
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [OFF_AWIDTH:0]                       cfg_words,
    input  logic [CH_NUM*HBM_AWIDTH-1:0]              cfg_base,
    output logic [CH_NUM*HBM_AWIDTH-1:0]              hbm_req_addr,
    output logic [CH_NUM-1:0]                         hbm_req_valid,
    input  logic [CH_NUM-1:0]                         hbm_req_ready,
    input  logic [CH_NUM*CORES_PER_CH*OFF_DWIDTH-1:0] hbm_rsp_data,
    input  logic [CH_NUM-1:0]                         hbm_rsp_valid,
    output logic                                      busy,
    output logic                                      load_done,
    input  logic [CORE_NUM-1:0]                       rd_valid,
    input  logic [CORE_NUM*OFF_AWIDTH-1:0]            rd_addr,
    output logic [CORE_NUM*OFF_DWIDTH-1:0]            loffset,
    output logic [CORE_NUM*OFF_DWIDTH-1:0]            roffset,
    output logic [CORE_NUM-1:0]                       rd_dvalid,
    output logic [CORE_NUM-1:0]                       rd_err
);

    localparam int WW = OFF_AWIDTH + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    state_e                             state_q, state_d;
    logic [WW-1:0]                      words_q;
    logic [CH_NUM-1:0][HBM_AWIDTH-1:0]  addr_q, addr_d;
    logic [CH_NUM-1:0][WW-1:0]          issued_q, issued_d, received_q, received_d;
    logic [CH_NUM-1:0][OW-1:0]          outst_q, outst_d;
    logic [CH_NUM-1:0]                  acc, rsp_ok, iss_done, rcv_done;
    logic                               run, load_ok;

    assign run          = (state_q == ISSUE) || (state_q == DRAIN);
    assign load_ok      = start && ((state_q == IDLE) || (state_q == DONE));
    assign busy         = run;
    assign load_done    = state_q == DONE;
    assign hbm_req_addr = addr_q;

    // Completion looks at next-cycle counts so load_done follows the final response by one cycle
    always_comb begin
        for (int c = 0; c < CH_NUM; c++) begin
            hbm_req_valid[c] = (state_q == ISSUE) && (issued_q[c] < words_q) &&
                               (outst_q[c] < OW'(MAX_OUTSTANDING));
            acc[c]           = hbm_req_valid[c] && hbm_req_ready[c];
            rsp_ok[c]        = run && hbm_rsp_valid[c] && (received_q[c] < words_q);
            addr_d[c]        = addr_q[c] + HBM_AWIDTH'(acc[c]);
            issued_d[c]      = issued_q[c] + WW'(acc[c]);
            received_d[c]    = received_q[c] + WW'(rsp_ok[c]);
            outst_d[c]       = outst_q[c] + OW'(acc[c]) - OW'(rsp_ok[c]);
            iss_done[c]      = issued_d[c] == words_q;
            rcv_done[c]      = received_d[c] == words_q;
        end
        state_d = &rcv_done ? DONE : &iss_done ? DRAIN : ISSUE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            words_q    <= '0;
            addr_q     <= '0;
            issued_q   <= '0;
            received_q <= '0;
            outst_q    <= '0;
        end else if (load_ok) begin
            state_q    <= (cfg_words == '0) ? DONE : ISSUE;
            words_q    <= cfg_words;
            addr_q     <= cfg_base;
            issued_q   <= '0;
            received_q <= '0;
            outst_q    <= '0;
        end else if (run) begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            outst_q    <= outst_d;
        end
    end

    for (genvar i = 0; i < CORE_NUM; i++) begin : g_core
        localparam int CH = core_ch(i, CORES_PER_CH);
        offset_bank_pair #(
            .OFF_DWIDTH (OFF_DWIDTH),
            .OFF_AWIDTH (OFF_AWIDTH),
            .RD_LAT     (RD_LAT)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (rsp_ok[CH]),
            .wr_idx    (received_q[CH][OFF_AWIDTH-1:0]),
            .wr_data   (hbm_rsp_data[lane_base(i, CORES_PER_CH, OFF_DWIDTH) +: OFF_DWIDTH]),
            .rd_valid  (rd_valid[i] && load_done),
            .rd_addr   (rd_addr[i*OFF_AWIDTH +: OFF_AWIDTH]),
            .rd_limit  (words_q),
            .loffset   (loffset[i*OFF_DWIDTH +: OFF_DWIDTH]),
            .roffset   (roffset[i*OFF_DWIDTH +: OFF_DWIDTH]),
            .rd_dvalid (rd_dvalid[i]),
            .rd_err    (rd_err[i])
        );
    end

endmodule

// File: tb/tb_offset_pair_loader.sv
// tb_offset_pair_loader: directed checks of load, credit limiting, reset abort and paired reads
module tb_offset_pair_loader;

    localparam int RD_LAT = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  cfg_words = '0;
    logic [15:0] cfg_base = '0;
    logic [15:0] hbm_req_addr;
    logic [0:0]  hbm_req_valid;
    logic [0:0]  hbm_req_ready = '0;
    logic [63:0] hbm_rsp_data = '0;
    logic [0:0]  hbm_rsp_valid = '0;
    logic        busy, load_done;
    logic [1:0]  rd_valid = '0;
    logic [11:0] rd_addr = '0;
    logic [63:0] loffset, roffset;
    logic [1:0]  rd_dvalid, rd_err;

    int checks = 0;
    int errors = 0;
    int acc_n, rsp_n, out_n, max_out;
    bit rdy, rsp_en, rsp_now, seen_dv, ok, last;
    logic [15:0] base_cur;
    logic [15:0] pend_q[$];
    logic [15:0] acc_addr[$];

    offset_pair_loader #(
        .CH_NUM(1), .CORES_PER_CH(2), .OFF_DWIDTH(32), .OFF_AWIDTH(6),
        .HBM_AWIDTH(16), .MAX_OUTSTANDING(4), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_words(cfg_words), .cfg_base(cfg_base),
        .hbm_req_addr(hbm_req_addr), .hbm_req_valid(hbm_req_valid), .hbm_req_ready(hbm_req_ready),
        .hbm_rsp_data(hbm_rsp_data), .hbm_rsp_valid(hbm_rsp_valid), .busy(busy), .load_done(load_done),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .loffset(loffset), .roffset(roffset),
        .rd_dvalid(rd_dvalid), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive HBM side at negedge, record handshakes, leave time at posedge+1
    task automatic step();
        logic [15:0] idx;
        int v;
        bit a;
        @(negedge clk);
        rsp_now = rsp_en && (pend_q.size() > 0);
        hbm_req_ready = rdy;
        hbm_rsp_valid = rsp_now;
        hbm_rsp_data = '0;
        if (rsp_now) begin
            idx = pend_q.pop_front() - base_cur;
            v = 10 * (int'(idx) + 1);
            hbm_rsp_data = {32'(v + 1000), 32'(v)};
        end
        #1;
        a = hbm_req_valid[0] && hbm_req_ready[0];
        if (a) begin
            acc_addr.push_back(hbm_req_addr);
            pend_q.push_back(hbm_req_addr);
            acc_n++;
        end
        rsp_n += int'(rsp_now);
        out_n += int'(a) - int'(rsp_now);
        if (out_n > max_out) max_out = out_n;
        @(posedge clk);
        #1;
        start = 1'b0;
        rd_valid = '0;
        if (|rd_dvalid) seen_dv = 1'b1;
    endtask

    task automatic clear_counts(input logic [15:0] base);
        acc_n = 0; rsp_n = 0; out_n = 0; max_out = 0; seen_dv = 1'b0;
        acc_addr.delete();
        base_cur = base;
    endtask

    task automatic do_start(input logic [6:0] words, input logic [15:0] base);
        clear_counts(base);
        cfg_words = words;
        cfg_base = base;
        start = 1'b1;
        step();
    endtask

    task automatic run_until_done(input int budget, output bit done_ok, output bit last_rsp);
        done_ok = 1'b0;
        last_rsp = 1'b0;
        for (int i = 0; i < budget && !done_ok; i++) begin
            step();
            done_ok = load_done;
            last_rsp = rsp_now;
        end
    endtask

    task automatic do_read(input string tag, input logic [5:0] a, input logic [31:0] l0,
                           input logic [31:0] r0, input logic err, input bit chk_r);
        rd_addr = {a, a};
        rd_valid = 2'b11;
        for (int i = 0; i < RD_LAT - 1; i++) step();
        chk({tag, "_early"}, rd_dvalid, 2'b00);
        step();
        chk({tag, "_dvalid"}, rd_dvalid, 2'b11);
        chk({tag, "_loff"}, loffset, {l0 + 32'd1000, l0});
        if (chk_r) chk({tag, "_roff"}, roffset, {r0 + 32'd1000, r0});
        chk({tag, "_err"}, rd_err, {err, err});
    endtask

    initial begin
        bit stall;
        clear_counts(16'h0);
        rdy = 1'b0;
        rsp_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req_valid", hbm_req_valid, 1'b0);
        chk("rst_req_addr", hbm_req_addr, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", load_done, 1'b0);
        chk("rst_dvalid", rd_dvalid, 2'b00);
        chk("rst_err", rd_err, 2'b00);
        chk("rst_loff", loffset, 64'h0);
        chk("rst_roff", roffset, 64'h0);

        // Basic 5-word load with ready held high
        rdy = 1'b1;
        rsp_en = 1'b1;
        do_start(7'd5, 16'h0100);
        chk("t1_valid_after_start", hbm_req_valid, 1'b1);
        chk("t1_busy", busy, 1'b1);
        run_until_done(50, ok, last);
        chk("t1_done", ok, 1'b1);
        chk("t1_done_after_last_rsp", last, 1'b1);
        chk("t1_req_count", acc_n, 5);
        chk("t1_rsp_count", rsp_n, 5);
        for (int i = 0; i < 5; i++) chk("t1_req_addr", acc_addr[i], 16'h0100 + 16'(i));
        do_read("t1_a0", 6'd0, 32'd10, 32'd20, 1'b0, 1'b1);
        do_read("t1_a2", 6'd2, 32'd30, 32'd40, 1'b0, 1'b1);
        do_read("t1_a3", 6'd3, 32'd40, 32'd50, 1'b0, 1'b1);
        do_read("t1_a4", 6'd4, 32'd50, 32'd0, 1'b1, 1'b0);

        // Credit limit with stalled ready and delayed responses
        rdy = 1'b0;
        rsp_en = 1'b0;
        do_start(7'd8, 16'h0200);
        rd_addr = 12'h0;
        rd_valid = 2'b11;
        repeat (10) step();
        chk("t2_no_accept_unready", acc_n, 0);
        chk("t2_valid_held", hbm_req_valid, 1'b1);
        rdy = 1'b1;
        repeat (6) step();
        chk("t2_credit_cap", acc_n, 4);
        chk("t2_valid_blocked", hbm_req_valid, 1'b0);
        chk("t2_first_addr", acc_addr[0], 16'h0200);
        rsp_en = 1'b1;
        step();
        rsp_en = 1'b0;
        chk("t2_resume", hbm_req_valid, 1'b1);
        rsp_en = 1'b1;
        run_until_done(100, ok, last);
        chk("t2_done", ok, 1'b1);
        chk("t2_max_outstanding", max_out, 4);
        chk("t2_rsp_count", rsp_n, 8);
        chk("t2_no_read_before_done", seen_dv, 1'b0);
        do_read("t2_a6", 6'd6, 32'd70, 32'd80, 1'b0, 1'b1);
        do_read("t2_a7", 6'd7, 32'd80, 32'd0, 1'b1, 1'b0);

        // Zero-length load
        do_start(7'd0, 16'h0400);
        chk("t3_done", load_done, 1'b1);
        chk("t3_no_valid", hbm_req_valid, 1'b0);
        chk("t3_busy", busy, 1'b0);
        step();
        chk("t3_no_accept", acc_n, 0);

        // Reset mid-load, late responses, then full reload
        rdy = 1'b1;
        rsp_en = 1'b1;
        do_start(7'd8, 16'h0300);
        for (int i = 0; i < 20 && rsp_n < 3; i++) step();
        chk("t4_three_rsp", rsp_n, 3);
        rsp_en = 1'b0;
        repeat (4) step();
        chk("t4_busy_before_rst", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_rst_busy", busy, 1'b0);
        chk("t4_rst_valid", hbm_req_valid, 1'b0);
        chk("t4_rst_addr", hbm_req_addr, 16'h0);
        chk("t4_rst_done", load_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        acc_n = 0;
        rsp_en = 1'b1;
        repeat (6) step();
        chk("t4_late_drained", pend_q.size(), 0);
        chk("t4_no_req_after_rst", acc_n, 0);
        chk("t4_idle_busy", busy, 1'b0);
        chk("t4_idle_done", load_done, 1'b0);
        do_start(7'd8, 16'h0300);
        run_until_done(100, ok, last);
        chk("t4_reload_done", ok, 1'b1);
        chk("t4_reload_rsp", rsp_n, 8);
        do_read("t4_a5", 6'd5, 32'd60, 32'd70, 1'b0, 1'b1);

        // 64 beats back to back with address wrap
        rdy = 1'b1;
        rsp_en = 1'b1;
        stall = 1'b0;
        do_start(7'd64, 16'hFFF0);
        for (int i = 0; i < 200 && !load_done; i++) begin
            if (acc_n < 64 && !hbm_req_valid[0]) stall = 1'b1;
            step();
        end
        chk("t5_done", load_done, 1'b1);
        chk("t5_no_stall", stall, 1'b0);
        chk("t5_req_count", acc_n, 64);
        chk("t5_rsp_count", rsp_n, 64);
        chk("t5_outstanding_const", max_out, 1);
        chk("t5_addr_pre_wrap", acc_addr[15], 16'hFFFF);
        chk("t5_addr_post_wrap", acc_addr[17], 16'h0001);
        do_read("t5_a31", 6'd31, 32'd320, 32'd330, 1'b0, 1'b1);
        do_read("t5_a62", 6'd62, 32'd630, 32'd640, 1'b0, 1'b1);
        do_read("t5_a63", 6'd63, 32'd640, 32'd0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
